// File: rtl/multipli_arbiter_pkg.sv
// Shared types and width helpers for the multiplier-sharing arbiter.
package multipli_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

  localparam int TAMANO_DEF  = 8;
  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 64;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int wd_w(input int t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/multipli_arbiter_if.sv
// Requester and multiplier-side signals of the arbiter, bundled for port connection.
interface multipli_arbiter_if #(
  parameter int tamano = 8,
  parameter int NREQ   = 4
);
  logic [NREQ-1:0]        REQ;
  logic [NREQ*tamano-1:0] REQ_A;
  logic [NREQ*tamano-1:0] REQ_B;
  logic [NREQ-1:0]        GNT;
  logic [NREQ-1:0]        RSP_VALID;
  logic [2*tamano-1:0]    RSP_S;
  logic                   RSP_ERR;
  logic                   BUSY;
  logic                   M_START;
  logic [tamano-1:0]      M_A;
  logic [tamano-1:0]      M_B;
  logic [2*tamano-1:0]    M_S;
  logic                   M_END;

  modport slave (
    input  REQ, REQ_A, REQ_B, M_S, M_END,
    output GNT, RSP_VALID, RSP_S, RSP_ERR, BUSY, M_START, M_A, M_B
  );

  modport master (
    output REQ, REQ_A, REQ_B, M_S, M_END,
    input  GNT, RSP_VALID, RSP_S, RSP_ERR, BUSY, M_START, M_A, M_B
  );
endinterface

// File: rtl/multipli_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or above the pointer, with wrap.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W:0] w_dist;
  logic [IDX_W:0] w_best;

  // The requester closest to the pointer (in wrapped distance) wins.
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_dist = '0;
    w_best = '1;
    for (int j = 0; j < NREQ; j++) begin
      if (IDX_W'(j) >= i_ptr) w_dist = (IDX_W+1)'(j) - {1'b0, i_ptr};
      else                    w_dist = (IDX_W+1)'(j + NREQ) - {1'b0, i_ptr};
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IDX_W'(j);
        o_any  = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      o_gnt[j] = o_any && (o_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/multipli_arbiter.sv
// Round-robin sequencer sharing one sequential multiplier between NREQ requesters,
// with a watchdog that aborts an operation whose END never arrives.
module multipli_arbiter
  import multipli_arb_pkg::*;
#(
  parameter int tamano  = TAMANO_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               CLOCK,
  input logic               RESET,
  multipli_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NREQ);
  localparam int WD_W  = wd_w(TIMEOUT);

  arb_state_e          r_state, w_state;
  logic [IDX_W-1:0]    r_owner, w_owner;
  logic [IDX_W-1:0]    r_ptr,   w_ptr;
  logic [WD_W-1:0]     r_wd,    w_wd;
  logic [NREQ-1:0]     r_gnt,   w_gnt;
  logic [NREQ-1:0]     r_rsp_valid, w_rsp_valid;
  logic [2*tamano-1:0] r_rsp_s, w_rsp_s;
  logic                r_rsp_err, w_rsp_err;
  logic                r_busy,  w_busy;
  logic                r_start, w_start;
  logic [tamano-1:0]   r_m_a,   w_m_a;
  logic [tamano-1:0]   r_m_b,   w_m_b;

  logic [NREQ-1:0]     w_pick_gnt;
  logic [IDX_W-1:0]    w_pick_idx;
  logic                w_pick_any;
  logic [tamano-1:0]   w_sel_a, w_sel_b;
  logic [NREQ-1:0]     w_owner_oh;
  logic [WD_W-1:0]     w_wd_inc;

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .i_req (bus.REQ),
    .i_ptr (r_ptr),
    .o_gnt (w_pick_gnt),
    .o_idx (w_pick_idx),
    .o_any (w_pick_any)
  );

  always_comb begin
    w_sel_a    = '0;
    w_sel_b    = '0;
    w_owner_oh = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (w_pick_gnt[j]) begin
        w_sel_a = bus.REQ_A[j*tamano +: tamano];
        w_sel_b = bus.REQ_B[j*tamano +: tamano];
      end
      w_owner_oh[j] = (r_owner == IDX_W'(j));
    end
  end

  always_comb begin
    w_state     = r_state;
    w_owner     = r_owner;
    w_ptr       = r_ptr;
    w_wd        = r_wd;
    w_gnt       = '0;
    w_rsp_valid = '0;
    w_rsp_s     = r_rsp_s;
    w_rsp_err   = r_rsp_err;
    w_start     = 1'b0;
    w_m_a       = r_m_a;
    w_m_b       = r_m_b;
    w_wd_inc    = r_wd + 1'b1;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_state = LAUNCH;
          w_owner = w_pick_idx;
          w_ptr   = (w_pick_idx == IDX_W'(NREQ-1)) ? '0 : w_pick_idx + 1'b1;
          w_gnt   = w_pick_gnt;
          w_start = 1'b1;
          w_m_a   = w_sel_a;
          w_m_b   = w_sel_b;
        end
      end
      LAUNCH: begin
        w_state = WAIT;
        w_wd    = '0;
      end
      WAIT: begin
        w_wd = w_wd_inc;
        // r_wd == 0 marks the first WAIT cycle, where a stale END may still be high.
        if (bus.M_END && (r_wd != '0)) begin
          w_state     = DONE;
          w_rsp_s     = bus.M_S;
          w_rsp_err   = 1'b0;
          w_rsp_valid = w_owner_oh;
        end else if (w_wd_inc == WD_W'(TIMEOUT)) begin
          w_state     = DONE;
          w_rsp_s     = '0;
          w_rsp_err   = 1'b1;
          w_rsp_valid = w_owner_oh;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_ptr       <= '0;
      r_wd        <= '0;
      r_gnt       <= '0;
      r_rsp_valid <= '0;
      r_rsp_s     <= '0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_m_a       <= '0;
      r_m_b       <= '0;
    end else begin
      r_state     <= w_state;
      r_owner     <= w_owner;
      r_ptr       <= w_ptr;
      r_wd        <= w_wd;
      r_gnt       <= w_gnt;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_s     <= w_rsp_s;
      r_rsp_err   <= w_rsp_err;
      r_busy      <= w_busy;
      r_start     <= w_start;
      r_m_a       <= w_m_a;
      r_m_b       <= w_m_b;
    end
  end

  assign bus.GNT       = r_gnt;
  assign bus.RSP_VALID = r_rsp_valid;
  assign bus.RSP_S     = r_rsp_s;
  assign bus.RSP_ERR   = r_rsp_err;
  assign bus.BUSY      = r_busy;
  assign bus.M_START   = r_start;
  assign bus.M_A       = r_m_a;
  assign bus.M_B       = r_m_b;

endmodule

// File: tb/tb_multipli_arbiter.sv
// Bench for multipli_arbiter: behavioural multiplier stub plus a round-robin reference model.
module tb_multipli_arbiter;

  localparam int TAM = 8;
  localparam int NR  = 4;
  localparam int TO  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multipli_arbiter_if #(.tamano(TAM), .NREQ(NR)) bus ();

  multipli_arbiter #(.tamano(TAM), .NREQ(NR), .TIMEOUT(TO)) dut (
    .CLOCK (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    return 16'(ia * ib);
  endfunction

  // Multiplier stub. Mode 0: END after stub_lat cycles, held high until next START.
  // Mode 1: END never comes. Mode 2: END left high, S refreshed one cycle after START.
  int          stub_mode = 0;
  int          stub_lat  = 3;
  int          s_cnt;
  logic [15:0] s_prod;
  logic [15:0] s_s;
  logic        s_end;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_end  <= 1'b0;
      s_s    <= '0;
      s_cnt  <= 0;
      s_prod <= '0;
    end else if (bus.M_START) begin
      s_prod <= ref_prod(bus.M_A, bus.M_B);
      if (stub_mode == 2) s_cnt <= 1;
      else begin
        s_end <= 1'b0;
        s_cnt <= stub_lat;
      end
    end else if (s_cnt > 0) begin
      s_cnt <= s_cnt - 1;
      if (s_cnt == 1 && stub_mode != 1) begin
        s_end <= 1'b1;
        s_s   <= s_prod;
      end
    end
  end

  assign bus.M_S   = s_s;
  assign bus.M_END = s_end;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester drive state and the values the arbiter will sample at the next edge.
  logic [NR-1:0] drv_req;
  logic [7:0]    drv_a [NR];
  logic [7:0]    drv_b [NR];
  logic [NR-1:0] prev_req;
  logic [7:0]    prev_a [NR];
  logic [7:0]    prev_b [NR];
  bit            rand_en = 1'b0;

  // Reference model state.
  int          m_ptr;
  bit          m_idle;
  bit          m_out;
  int          m_owner;
  int          m_wait;
  logic [15:0] m_exp_s;
  bit          m_exp_err;
  bit          rsp_prev;
  int          cyc = 0;
  int          grant_cyc = 0;
  int          last_lat = 0;
  int          glog[$];
  logic [15:0] slog[$];

  function automatic int rr_winner(input logic [NR-1:0] req, input int ptr);
    for (int k = 0; k < NR; k++) begin
      if (req[(ptr + k) % NR]) return (ptr + k) % NR;
    end
    return -1;
  endfunction

  task automatic apply();
    for (int i = 0; i < NR; i++) begin
      bus.REQ[i]             = drv_req[i];
      bus.REQ_A[i*TAM +: TAM] = drv_a[i];
      bus.REQ_B[i*TAM +: TAM] = drv_b[i];
      prev_a[i] = drv_a[i];
      prev_b[i] = drv_b[i];
    end
    prev_req = drv_req;
  endtask

  task automatic post(input int i, input logic [7:0] a, input logic [7:0] b);
    drv_req[i] = 1'b1;
    drv_a[i]   = a;
    drv_b[i]   = b;
    apply();
  endtask

  task automatic model_reset();
    m_ptr = 0; m_idle = 1'b1; m_out = 1'b0; rsp_prev = 1'b0; m_wait = 0;
    drv_req = '0;
    apply();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},   bus.GNT, '0);
    chk({tag, "_rspv"},  bus.RSP_VALID, '0);
    chk({tag, "_rsps"},  bus.RSP_S, '0);
    chk({tag, "_err"},   bus.RSP_ERR, '0);
    chk({tag, "_busy"},  bus.BUSY, '0);
    chk({tag, "_start"}, bus.M_START, '0);
    chk({tag, "_ma"},    bus.M_A, '0);
    chk({tag, "_mb"},    bus.M_B, '0);
  endtask

  task automatic step();
    logic [NR-1:0] g, r, eg;
    int  w;
    bit  new_idle;
    @(negedge clk);
    cyc++;
    g  = bus.GNT;
    r  = bus.RSP_VALID;
    eg = '0;
    w  = -1;
    if (m_idle && prev_req != '0) begin
      w = rr_winner(prev_req, m_ptr);
      eg[w] = 1'b1;
    end
    chk("gnt", g, eg);
    chk("m_start", bus.M_START, (eg != '0));
    if (w >= 0) begin
      chk("m_a", bus.M_A, prev_a[w]);
      chk("m_b", bus.M_B, prev_b[w]);
      m_ptr     = (w + 1) % NR;
      m_owner   = w;
      m_out     = 1'b1;
      m_wait    = 0;
      m_exp_s   = (stub_mode == 1) ? 16'h0000 : ref_prod(prev_a[w], prev_b[w]);
      m_exp_err = (stub_mode == 1);
      grant_cyc = cyc;
      glog.push_back(w);
    end
    if (r != '0) begin
      if (!m_out) chk("rsp_unexpected", r, '0);
      else begin
        chk("rsp_owner", r, NR'(1) << m_owner);
        chk("rsp_s", bus.RSP_S, m_exp_s);
        chk("rsp_err", bus.RSP_ERR, m_exp_err);
        slog.push_back(bus.RSP_S);
        last_lat = cyc - grant_cyc;
        m_out = 1'b0;
      end
    end else if (m_out && w < 0) begin
      m_wait++;
      if (m_wait > TO + 8) begin
        chk("rsp_missing", m_wait, TO + 1);
        m_out = 1'b0;
      end
    end
    new_idle = rsp_prev || (m_idle && prev_req == '0);
    chk("busy", bus.BUSY, !new_idle);
    m_idle   = new_idle;
    rsp_prev = (r != '0);

    for (int i = 0; i < NR; i++) begin
      if (g[i]) drv_req[i] = 1'b0;
      if (rand_en) begin
        if (!drv_req[i] && $urandom_range(0, 3) == 0) begin
          drv_req[i] = 1'b1;
          drv_a[i]   = 8'($urandom);
          drv_b[i]   = 8'($urandom);
        end else if (drv_req[i] && $urandom_range(0, 63) == 0) begin
          drv_req[i] = 1'b0;
        end
      end
    end
    if (rand_en) begin
      stub_lat = $urandom_range(1, 12);
      if (!m_out && eg == '0) begin
        w = $urandom_range(0, 19);
        stub_mode = (w < 16) ? 0 : (w < 19) ? 2 : 1;
      end
    end
    apply();
  endtask

  task automatic run_resp(input int n, input int budget);
    int b;
    b = budget;
    while (slog.size() < n && b > 0) begin
      step();
      b--;
    end
    if (slog.size() < n) chk("resp_budget", slog.size(), n);
  endtask

  task automatic hard_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      drv_a[i] = '0;
      drv_b[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    chk_reset_outputs("por");
    rst_n = 1'b1;

    // Single request from requester 2.
    glog.delete(); slog.delete();
    stub_mode = 0; stub_lat = 3;
    post(2, 8'd7, 8'hFD);
    run_resp(1, 200);
    if (slog.size() >= 1) begin
      chk("single_s", slog[0], 16'hFFEB);
      chk("single_owner", glog[0], 2);
    end
    repeat (3) step();

    // All four at once after reset: served 0,1,2,3.
    hard_reset();
    glog.delete(); slog.delete();
    for (int i = 0; i < NR; i++) post(i, 8'(i + 1), 8'd10);
    run_resp(4, 400);
    for (int i = 0; i < NR; i++) begin
      if (i < glog.size()) chk("all4_order", glog[i], i);
      if (i < slog.size()) chk("all4_s", slog[i], 10 * (i + 1));
    end
    repeat (3) step();

    // Fairness: after a grant to 2, requesters 1 and 3 compete; 3 goes first.
    glog.delete(); slog.delete();
    post(2, 8'h11, 8'h22);
    run_resp(1, 200);
    step();
    post(1, 8'h80, 8'h7F);
    post(3, 8'hFF, 8'hFF);
    run_resp(3, 400);
    if (glog.size() >= 3) begin
      chk("fair_first", glog[1], 3);
      chk("fair_second", glog[2], 1);
    end
    repeat (3) step();

    // Timeout: END never arrives.
    glog.delete(); slog.delete();
    stub_mode = 1;
    post(1, 8'h05, 8'h06);
    run_resp(1, 200);
    chk("to_latency", last_lat, TO + 1);
    step();
    chk("to_busy_fall", bus.BUSY, 1'b0);
    repeat (2) step();

    // Stale END: one normal operation leaves END high, then the stub keeps it high.
    glog.delete(); slog.delete();
    stub_mode = 0; stub_lat = 2;
    post(0, 8'h13, 8'h0B);
    run_resp(1, 200);
    repeat (2) step();
    stub_mode = 2;
    post(2, 8'hF0, 8'h09);
    run_resp(2, 200);
    chk("stale_latency", last_lat, 3);
    repeat (3) step();

    // Randomized traffic.
    stub_mode = 0;
    rand_en = 1'b1;
    repeat (4000) step();
    rand_en = 1'b0;
    stub_mode = 0;
    begin
      int b;
      b = 3000;
      while ((drv_req != '0 || m_out) && b > 0) begin
        step();
        b--;
      end
      chk("drain", (drv_req != '0 || m_out), 1'b0);
    end
    repeat (3) step();

    // Reset in the middle of WAIT, then pointer must be back at 0.
    glog.delete(); slog.delete();
    stub_mode = 1;
    post(1, 8'h21, 8'h03);
    repeat (6) step();
    chk("mid_busy", bus.BUSY, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    stub_mode = 0; stub_lat = 4;
    glog.delete(); slog.delete();
    post(3, 8'h02, 8'h03);
    post(0, 8'h04, 8'h05);
    run_resp(2, 300);
    if (glog.size() >= 2) begin
      chk("midrst_first", glog[0], 0);
      chk("midrst_second", glog[1], 3);
    end
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multipli_arbiter.md
Name: multipli_arbiter

Overview:
Round-robin arbiter/sequencer that shares one sequential Booth multiplier instance (multipli, parameter tamano) between NREQ requesters. It accepts an operand pair from one requester at a time and drives the multiplier's START/A/B. It waits for END_MULT, or for a watchdog timeout, and returns the product to the owning requester. It sits between requester blocks and the multiplier's CLOCK/RESET/START/A/B/S/END_MULT interface.

Parameters:
tamano, 8, operand width; product width is 2*tamano
NREQ, 4, number of requesters (2..8)
TIMEOUT, 64, maximum WAIT cycles before aborting an operation

Ports:
CLOCK  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-low reset
REQ  in  NREQ  per-requester request level; held with operands until GNT seen
REQ_A  in  NREQ*tamano  packed operand A, slice i belongs to requester i
REQ_B  in  NREQ*tamano  packed operand B
GNT  out  NREQ  one-hot, one-cycle accept pulse
RSP_VALID  out  NREQ  one-hot, one-cycle result pulse to the owner
RSP_S  out  2*tamano  result, valid while RSP_VALID is nonzero
RSP_ERR  out  1  high with RSP_VALID when the operation timed out
BUSY  out  1  high in any state other than IDLE
M_START  out  1  to multiplier START
M_A  out  tamano  to multiplier A
M_B  out  tamano  to multiplier B
M_S  in  2*tamano  from multiplier S
M_END  in  1  from multiplier END_MULT

Behaviour:
- Reset (RESET=0, asynchronous): state IDLE; GNT, RSP_VALID, RSP_ERR, BUSY and M_START = 0; M_A, M_B and RSP_S = 0; pointer = 0; watchdog = 0. Reset mid-operation abandons the operation silently, with no RSP_VALID.
- FSM states: IDLE, LAUNCH, WAIT, DONE. All outputs are registered.
- IDLE: if REQ != 0, the winner is the first set bit searching from pointer upward with wrap. Latch the winner's A/B slices into M_A/M_B. Pulse GNT[winner] in the next cycle, go LAUNCH, set pointer = (winner+1) mod NREQ. If REQ == 0, stay in IDLE.
- LAUNCH (1 cycle): M_START=1, GNT[owner]=1. Go WAIT with watchdog = 0.
- WAIT: M_START=0. M_A/M_B stay stable until DONE.
  - M_END is ignored in the first WAIT cycle, so a level left high from the previous operation is not taken.
  - From the second WAIT cycle, M_END=1 captures M_S into RSP_S, RSP_ERR=0, go DONE.
  - The watchdog increments every WAIT cycle. On reaching TIMEOUT without M_END: RSP_S=0, RSP_ERR=1, go DONE.
  - If M_END and the timeout occur in the same cycle, M_END wins.
- DONE (1 cycle): RSP_VALID[owner]=1, with RSP_S/RSP_ERR valid. Return to IDLE.
- RSP_S/RSP_ERR hold their value until the next DONE. There is no response backpressure; requesters must sample in the DONE cycle.
- Latency, REQ sampled to RSP_VALID: 3 + (cycles until M_END in WAIT). Back-to-back service puts at least 1 IDLE cycle between RSP_VALID and the next GNT.
- REQ from the current owner during LAUNCH/WAIT/DONE is ignored. A requester that drops REQ before being granted loses its turn with no side effects.
- Products are passed through unmodified (two's complement, 2*tamano bits). The arbiter performs no arithmetic.

Decomposition:
- Package multipli_arb_pkg: state enum (IDLE, LAUNCH, WAIT, DONE); IDX_W = $clog2(NREQ) helper; WD_W = $clog2(TIMEOUT+1).
- Sub-module rr_pick: combinational round-robin picker. Inputs: req vector, pointer. Outputs: one-hot grant, index, any.
- The arbiter top holds the FSM, operand mux, watchdog and response registers.

Test Plan:
- Single request, tamano=8, NREQ=4: requester 2, A=8'd7, B=8'hFD → GNT[2] pulse, M_START one cycle later paired with GNT[2], RSP_VALID[2] with RSP_S=16'hFFEB, RSP_ERR=0.
- All four REQ asserted after reset, each A=i+1, B=8'd10 → grants in order 0,1,2,3; RSP_S = 10, 20, 30, 40; exactly one GNT and one RSP_VALID bit high at any time.
- Fairness: after a grant to 2, assert REQ[1] and REQ[3] together → 3 is served before 1.
- Timeout: replace the multiplier with a stub holding M_END=0 → RSP_VALID pulse after exactly 64 WAIT cycles, RSP_ERR=1, RSP_S=0. BUSY falls one cycle after that pulse.
- Stale END: stub holds M_END=1 after a completed operation; start the next request → first WAIT cycle ignored, capture on the second, correct product returned.
- Reset mid-WAIT: drop RESET for 1 cycle → all outputs 0 immediately with no RSP_VALID; a new REQ[3] with REQ[0] → port 0 granted first (pointer reset).
